// File: rtl/ft_pkg.sv
// Shared types and default widths for the lockstep fault-tolerance controller.
// Recovery FSM states plus default register-file geometry.
package ft_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECOVER = 2'd1,
        RESUME  = 2'd2
    } state_t;

endpackage

// File: rtl/ft_shadow_rf.sv
// Golden shadow register file: one synchronous write port, one async read port.
// Write lands on the next rising edge; read is combinational; no backpressure.
module ft_shadow_rf #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/ft_lockstep_ctrl.sv
// Lockstep pair checker: one-cycle detection latency, then halts both cores while the
// golden register file is replayed (2**ADDR_WIDTH cycles) and a one-cycle resume pulse.
module ft_lockstep_ctrl
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_a_i,
    input  logic                  we_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    input  logic [DATA_WIDTH-1:0] spc_i,
    output logic [DATA_WIDTH-1:0] spc_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  halt_o,
    output logic                  resume_o
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   spc_q, spc_d;
    logic                    mismatch;
    logic                    sh_we;
    logic [DATA_WIDTH-1:0]   sh_rd_dat;
    logic                    halt, resume;
    logic [ADDR_WIDTH-1:0]   rst_addr;
    logic [DATA_WIDTH-1:0]   rst_dat;

    // Address/data only matter when both cores actually write.
    always_comb begin
        mismatch = 1'b0;
        if (state_q == IDLE) begin
            mismatch = (we_a_i != we_b_i) ||
                       (we_a_i && we_b_i &&
                        ((addr_a_i != addr_b_i) || (data_a_i != data_b_i)));
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        spc_d    = spc_q;
        sh_we    = 1'b0;
        halt     = 1'b0;
        resume   = 1'b0;
        rst_addr = '0;
        rst_dat  = '0;
        case (state_q)
            IDLE: begin
                if (mismatch) begin
                    state_d = RECOVER;
                    cnt_d   = '0;
                end else begin
                    sh_we = we_a_i & we_b_i;
                    spc_d = spc_i;
                end
            end
            RECOVER: begin
                halt     = 1'b1;
                rst_addr = cnt_q;
                rst_dat  = sh_rd_dat;
                cnt_d    = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = RESUME;
                end
            end
            RESUME: begin
                halt    = 1'b1;
                resume  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            spc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            spc_q   <= spc_d;
        end
    end

    ft_shadow_rf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shadow (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (sh_we),
        .wr_addr (addr_a_i),
        .wr_dat  (data_a_i),
        .rd_addr (cnt_q),
        .rd_dat  (sh_rd_dat)
    );

    assign spc_o    = spc_q;
    assign addr_o   = rst_addr;
    assign data_o   = rst_dat;
    assign halt_o   = halt;
    assign resume_o = resume;

endmodule

// File: tb/tb_ft_lockstep_ctrl.sv
// Randomized scoreboard bench for ft_lockstep_ctrl against a cycle-indexed reference model.
module tb_ft_lockstep_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          we_a_i = 1'b0, we_b_i = 1'b0;
    logic [AW-1:0] addr_a_i = '0, addr_b_i = '0;
    logic [DW-1:0] data_a_i = '0, data_b_i = '0;
    logic [DW-1:0] spc_i = '0;
    logic [DW-1:0] spc_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_o;
    logic          halt_o, resume_o;

    ft_lockstep_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .we_a_i   (we_a_i),
        .we_b_i   (we_b_i),
        .addr_a_i (addr_a_i),
        .addr_b_i (addr_b_i),
        .data_a_i (data_a_i),
        .data_b_i (data_b_i),
        .spc_i    (spc_i),
        .spc_o    (spc_o),
        .addr_o   (addr_o),
        .data_o   (data_o),
        .halt_o   (halt_o),
        .resume_o (resume_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          halt;
        logic          resume;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] spc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: golden array, checkpoint PC and the index of the current
    // cycle within a recovery episode (-1 when running, 0..N-1 replay, N resume pulse).
    logic [DW-1:0] m_shadow [N];
    logic [DW-1:0] m_spc;
    int            m_phase;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=0x%0h expected=0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents its outputs; compare against the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("halt",   DW'(halt_o),   DW'(e.halt));
                chk("resume", DW'(resume_o), DW'(e.resume));
                chk("addr",   DW'(addr_o),   DW'(e.addr));
                chk("data",   data_o,        e.data);
                chk("spc",    spc_o,         e.spc);
            end
        end
    end

    task automatic step(input logic r, input logic wa, input logic wb,
                        input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                        input logic [DW-1:0] da, input logic [DW-1:0] db,
                        input logic [DW-1:0] pc);
        exp_t e;
        bit   diverge;
        @(negedge clk);
        rst_i = r; we_a_i = wa; we_b_i = wb;
        addr_a_i = aa; addr_b_i = ab; data_a_i = da; data_b_i = db; spc_i = pc;
        if (r) begin
            for (int i = 0; i < N; i++) m_shadow[i] = '0;
            m_spc   = '0;
            m_phase = -1;
        end else if (m_phase < 0) begin
            diverge = (wa != wb) || (wa && wb && (aa != ab || da != db));
            if (diverge) begin
                m_phase = 0;
            end else begin
                if (wa && wb) m_shadow[aa] = da;
                m_spc = pc;
            end
        end else if (m_phase < N) begin
            m_phase++;
        end else begin
            m_phase = -1;
        end
        e.halt   = (m_phase >= 0);
        e.resume = (m_phase == N);
        e.addr   = (m_phase >= 0 && m_phase < N) ? AW'(m_phase) : '0;
        e.data   = (m_phase >= 0 && m_phase < N) ? m_shadow[m_phase] : '0;
        e.spc    = m_spc;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycle(input logic [DW-1:0] pc);
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, pc);
    endtask

    task automatic garbage_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
                 $urandom, $urandom, $urandom);
        end
    endtask

    initial begin
        m_spc = '0;
        m_phase = -1;
        for (int i = 0; i < N; i++) m_shadow[i] = 'x;

        // Reset state.
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 32'h1234);
        step(1'b1, 1'b1, 1'b0, 5'd4, '0, 32'h9, '0, 32'h1234);

        // Golden writes then a one-sided write on addr 10; replay with idle inputs.
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, 1'b1, AW'(i), AW'(i), DW'(i * 10), DW'(i * 10), 32'h80);
        end
        step(1'b0, 1'b1, 1'b0, 5'd10, 5'd10, 32'd100, 32'd100, 32'h80);
        for (int k = 0; k < N + 3; k++) idle_cycle(32'h80);

        // Data-only divergence on addr 3, with garbage inputs during recovery.
        step(1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 32'd5, 32'd6, 32'h200);
        garbage_cycles(N + 1);

        // Disabled-write divergence is ignored; spc tracks every cycle.
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 1'b0, 5'd1, 5'd2, $urandom, $urandom, $urandom);
        end

        // Post-resume write to addr 10, then a new error replays it.
        step(1'b0, 1'b0, 1'b1, '0, '0, '0, '0, 32'h300);
        garbage_cycles(N + 1);
        step(1'b0, 1'b1, 1'b1, 5'd10, 5'd10, 32'd100, 32'd100, 32'h304);
        step(1'b0, 1'b1, 1'b1, 5'd7, 5'd8, 32'd1, 32'd1, 32'h308);
        garbage_cycles(N + 2);

        // Reset while counter = 12, then a fresh replay must be all zero.
        step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, 32'h400);
        garbage_cycles(12);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 32'h404);
        step(1'b0, 1'b1, 1'b1, 5'd2, 5'd2, 32'd1, 32'd2, 32'h408);
        garbage_cycles(N + 2);

        // Random traffic: mostly agreeing writes, occasional divergence, rare reset.
        for (int k = 0; k < 3000; k++) begin
            logic          wa, wb;
            logic [AW-1:0] aa, ab;
            logic [DW-1:0] da, db;
            wa = 1'($urandom_range(0, 3) != 0);
            wb = wa;
            aa = AW'($urandom); ab = aa;
            da = $urandom;      db = da;
            case ($urandom_range(0, 39))
                0: wb = ~wa;
                1: begin wa = 1'b1; wb = 1'b1; ab = aa ^ AW'($urandom_range(1, N - 1)); end
                2: begin wa = 1'b1; wb = 1'b1; db = da ^ 32'h1; end
                3: begin wa = 1'b0; wb = 1'b0; ab = AW'($urandom); db = $urandom; end
                default: ;
            endcase
            step(1'($urandom_range(0, 499) == 0), wa, wb, aa, ab, da, db, $urandom);
        end
        idle_cycle('0);

        @(posedge clk);
        #3;
        chk("drain", DW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ft_lockstep_ctrl.md
Name: ft_lockstep_ctrl

Overview:
- Fault-tolerance controller for a dual-core lockstep pair.
- Compares the register-file write ports of core A and core B every cycle.
- Keeps a golden shadow copy of the register file and the last good program counter, updated only from agreeing writes.
- On divergence it halts both cores, replays the golden register contents on a restore port, exposes the checkpointed PC, then signals resume.

Parameters:
- ADDR_WIDTH, 5, register-file address width; the file has 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register and PC data width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- we_a_i  in  1  core A register-file write enable.
- we_b_i  in  1  core B register-file write enable.
- addr_a_i  in  ADDR_WIDTH  core A write address.
- addr_b_i  in  ADDR_WIDTH  core B write address.
- data_a_i  in  DATA_WIDTH  core A write data.
- data_b_i  in  DATA_WIDTH  core B write data.
- spc_i  in  DATA_WIDTH  current program counter from the lockstep pair.
- spc_o  out  DATA_WIDTH  checkpointed PC (last PC sampled in an error-free cycle).
- addr_o  out  ADDR_WIDTH  restore-port register address.
- data_o  out  DATA_WIDTH  restore-port register data.
- halt_o  out  1  cores must stall.
- resume_o  out  1  one-cycle pulse: restore complete, cores may restart from spc_o.

Behaviour:
- Reset (rst_i=1 at an edge):
  - state IDLE, counter 0, all shadow entries 0, spc_o 0.
  - addr_o, data_o, halt_o and resume_o all 0.
  - Reset wins over every other event, including mid-recovery.
- Mismatch, combinational, evaluated only in IDLE. It is true when either:
  - we_a_i != we_b_i; or
  - we_a_i=we_b_i=1 and (addr_a_i != addr_b_i or data_a_i != data_b_i).
- Address and data differences are ignored when both write enables are 0.
- IDLE, no mismatch:
  - if we_a_i=we_b_i=1, write shadow[addr_a_i] <= data_a_i;
  - spc_o <= spc_i;
  - halt_o=0, resume_o=0, addr_o=0, data_o=0.
- IDLE, mismatch:
  - no shadow write and spc_o holds;
  - next state RECOVER, counter <= 0;
  - halt_o is 1 from the following cycle, i.e. one-cycle detection latency.
- RECOVER:
  - halt_o=1, resume_o=0;
  - addr_o=counter, data_o=shadow[counter]; asynchronous read driven from the registered counter;
  - counter increments each cycle;
  - after the cycle with counter = 2**ADDR_WIDTH-1, go to RESUME. RECOVER lasts exactly 2**ADDR_WIDTH cycles (32 by default).
- RESUME, one cycle:
  - halt_o=1, resume_o=1;
  - addr_o=0, data_o=0;
  - next state IDLE.
- Halt duration: halt_o is high for 2**ADDR_WIDTH+1 consecutive cycles per error.
- Inputs in RECOVER and RESUME: all we/addr/data/spc inputs are ignored. There is no shadow write, no spc_o update, and no new error detection.
- Write conflict: a write to the same address on the cycle after resume simply updates the shadow normally.
- spc_o is stable throughout RECOVER and RESUME.

Decomposition:
- Package ft_pkg:
  - state enum with IDLE, RECOVER, RESUME;
  - default width constants.
- Sub-module ft_shadow_rf holds the golden register file:
  - 2**ADDR_WIDTH x DATA_WIDTH entries;
  - one synchronous write port and one asynchronous read port;
  - synchronous clear on rst_i.
- Top level contains the comparator, the FSM, the counter and the spc checkpoint register.

Test Plan:
- Golden write and mismatch replay:
  - after reset, 32 cycles of matching writes reg i = i*10 with spc_i=0x80; then we_a_i=1, we_b_i=0, addr 10, data 100;
  - required: halt_o=1 on the next cycle and spc_o=0x80;
  - then addr_o steps 0..31 with data_o=0,10,...,310 (entry 10 = 100, not overwritten by the faulty write);
  - then one cycle with resume_o=1;
  - then halt_o=0.
- Data-only divergence: both we=1, addr 3, data_a=5, data_b=6 -> recovery starts; shadow[3] keeps its previous value.
- Disabled-write divergence: both we=0 with addr_a=1, addr_b=2 and differing data -> no halt; spc_o tracks spc_i every cycle.
- Recovery immunity: change spc_i and drive mismatching writes during RECOVER -> spc_o is unchanged, the replay sequence is unaffected, and it completes in 32 cycles.
- Reset mid-recovery: assert rst_i at counter=12 -> the next cycle shows halt_o=0, resume_o=0, spc_o=0, and a fresh replay returns all-zero data.
- Post-resume operation: a matching write addr 10, data 100 right after resume -> no halt, and the next error replays 100 at addr 10.
